// File: rtl/sar_afe_model_if.sv
// Sample/DAC/comparator bundle between the SAR controller and its analog front-end responder.
// The master side is the controller or bench; the slave side is sar_afe_model.
interface sar_afe_model_if #(
   parameter int unsigned Width = 6
);
   logic [Width-1:0] vin_i;
   logic             sample_i;
   logic [Width-1:0] dac_i;
   logic             eoc_i;
   logic [Width-1:0] result_i;
   logic             cmp_o;
   logic [Width-1:0] hold_o;
   logic             match_o;
   logic [7:0]       conv_cnt_o;
   logic [7:0]       err_cnt_o;
   logic [1:0]       state_o;

   modport master (
      output vin_i, sample_i, dac_i, eoc_i, result_i,
      input  cmp_o, hold_o, match_o, conv_cnt_o, err_cnt_o, state_o
   );

   modport slave (
      input  vin_i, sample_i, dac_i, eoc_i, result_i,
      output cmp_o, hold_o, match_o, conv_cnt_o, err_cnt_o, state_o
   );
endinterface

// File: rtl/sar_afe_model.sv
// Behavioural SAR front-end: sample-and-hold, offset comparator with programmable latency,
// and an end-of-conversion checker that counts conversions and errors.
module sar_afe_model #(
   parameter int unsigned Width  = 6,
   parameter int unsigned CmpLat = 1,
   parameter int          Offset = 0
) (
   input logic             clk_i,
   input logic             rst_i,
   sar_afe_model_if.slave  bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic signed [Width+1:0] OFF      = (Width+2)'(Offset);
   localparam logic signed [Width+1:0] CODE_MAX = {2'b00, {Width{1'b1}}};

   state_t                  state;
   state_t                  state_next;
   logic [Width-1:0]        held;
   logic                    eoc_prev;
   logic                    match;
   logic [7:0]              conv_cnt;
   logic [7:0]              err_cnt;
   logic                    eoc_rise;
   logic signed [Width+1:0] level;
   logic signed [Width+1:0] dac_ext;
   logic                    raw;
   logic [Width-1:0]        exp_code;
   logic                    accept;
   logic                    proto_err;
   logic                    hit;

   assign eoc_rise = bus.eoc_i & ~eoc_prev;
   assign level    = $signed({2'b00, held}) + OFF;
   assign dac_ext  = $signed({2'b00, bus.dac_i});
   assign raw      = (level >= dac_ext);
   assign hit      = (bus.result_i == exp_code);

   always_comb begin
      if (level < 0) begin
         exp_code = '0;
      end else if (level > CODE_MAX) begin
         exp_code = '1;
      end else begin
         exp_code = level[Width-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.sample_i) begin
         state_next = TRACK;
      end else begin
         unique case (state)
            TRACK:   state_next = HOLD;
            HOLD:    state_next = eoc_rise ? DONE : HOLD;
            default: state_next = state;
         endcase
      end
   end

   // sample_i wins over a coincident eoc rise, which then counts as a protocol error.
   always_comb begin
      bus.state_o = state;
      accept      = 1'b0;
      proto_err   = 1'b0;
      if (eoc_rise) begin
         if (!bus.sample_i && state == HOLD) begin
            accept = 1'b1;
         end else begin
            proto_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         held     <= '0;
         eoc_prev <= 1'b0;
         match    <= 1'b0;
         conv_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         eoc_prev <= bus.eoc_i;
         match    <= accept & hit;
         if (bus.sample_i) begin
            held <= bus.vin_i;
         end
         if (accept && conv_cnt != '1) begin
            conv_cnt <= conv_cnt + 8'd1;
         end
         if (((accept && !hit) || proto_err) && err_cnt != '1) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   generate
      if (CmpLat == 0) begin : g_cmp_comb
         assign bus.cmp_o = raw;
      end else begin : g_cmp_pipe
         logic [CmpLat-1:0] pipe;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               pipe <= '0;
            end else begin
               pipe[0] <= raw;
               for (int unsigned i = 1; i < CmpLat; i++) begin
                  pipe[i] <= pipe[i-1];
               end
            end
         end
         assign bus.cmp_o = pipe[CmpLat-1];
      end
   endgenerate

   assign bus.hold_o     = held;
   assign bus.match_o    = match;
   assign bus.conv_cnt_o = conv_cnt;
   assign bus.err_cnt_o  = err_cnt;
endmodule
